// File: rtl/timer_count_compare_pkg.sv
// Shared timer definitions: counter geometry, reset values, prescaler width and
// the half-word write helper used by both the counter and compare registers.
package timer_count_compare_pkg;

  localparam int CNT_W     = 64;
  localparam int HALF_W    = 32;
  localparam int TMR_DIV_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam cnt_t CNT_RST_VAL = 64'h0;

  // Replace the addressed half(s) with d; an untouched half keeps its value.
  function automatic cnt_t write_half(input cnt_t cur, input logic wr_lo,
                                      input logic wr_hi,
                                      input logic [HALF_W-1:0] d);
    cnt_t r;
    r = cur;
    if (wr_lo) r[HALF_W-1:0] = d;
    if (wr_hi) r[CNT_W-1:HALF_W] = d;
    return r;
  endfunction

endpackage

// File: rtl/timer_count_compare_if.sv
// Register-bank side of the timer: half-word write strobes plus full readback.
interface timer_count_compare_if;
  import timer_count_compare_pkg::*;

  // Strobe semantics: each *_wr_* is a single-cycle write enable with no
  // ready/ack; the write is always taken on the rising edge it is high for.
  logic              cnt_wr_lo;
  logic              cnt_wr_hi;
  logic              cmp_wr_lo;
  logic              cmp_wr_hi;
  logic [HALF_W-1:0] wdata;
  cnt_t              cnt;
  cnt_t              cmp;

  modport master (
    output cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi, wdata,
    input  cnt, cmp
  );

  modport slave (
    input  cnt_wr_lo, cnt_wr_hi, cmp_wr_lo, cmp_wr_hi, wdata,
    output cnt, cmp
  );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: divides the system clock by div_val+1 and emits a one-cycle tick
// whenever counting is allowed; restarts from zero on any disturbance.
module timer_prescaler
  import timer_count_compare_pkg::*;
#(
  parameter int DIV_W = TMR_DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halt_req,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             run_ok;
  logic             val_chg;

  always_comb begin
    run_ok    = timer_en & ~halt_req;
    val_chg   = (div_val != shadow_q);
    // A divisor change suppresses the tick so the new ratio starts cleanly.
    tick      = run_ok & (~div_en | (~val_chg & (div_cnt_q == div_val)));
    shadow_d  = div_val;
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (!run_ok || !div_en || val_chg || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt_q <= '0;
      shadow_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: rtl/timer_count_compare.sv
// Timer count/compare stage: 64-bit free-running counter, 64-bit compare
// register and the registered match level consumed by the interrupt stage.
module timer_count_compare
  import timer_count_compare_pkg::*;
#(
  parameter int   DIV_W   = TMR_DIV_W,
  parameter cnt_t CMP_RST = CMP_RST_VAL,
  parameter cnt_t CNT_RST = CNT_RST_VAL
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  timer_en,
  input  logic                  div_en,
  input  logic [DIV_W-1:0]      div_val,
  input  logic                  halt_req,
  timer_count_compare_if.slave  bus,
  output logic                  match,
  output logic                  halt_ack
);

  logic tick;
  cnt_t cnt_q, cnt_d;
  cnt_t cmp_q, cmp_d;
  logic match_q, match_d;
  logic halt_ack_q, halt_ack_d;

  timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .halt_req (halt_req),
    .tick     (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    // A write wins over the tick; the unwritten half neither increments nor
    // receives a carry.
    if (bus.cnt_wr_lo || bus.cnt_wr_hi) begin
      cnt_d = write_half(cnt_q, bus.cnt_wr_lo, bus.cnt_wr_hi, bus.wdata);
    end else if (tick) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
    cmp_d      = write_half(cmp_q, bus.cmp_wr_lo, bus.cmp_wr_hi, bus.wdata);
    match_d    = (cnt_q == cmp_q);
    halt_ack_d = halt_req;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q      <= CNT_RST;
      cmp_q      <= CMP_RST;
      match_q    <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.cmp  = cmp_q;
  assign match    = match_q;
  assign halt_ack = halt_ack_q;

endmodule

// File: tb/tb_timer_count_compare.sv
// Bench for timer_count_compare: directed scenarios pinned with literal values,
// then random traffic checked every cycle against a cycle-level reference model.
module tb_timer_count_compare;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        match;
  logic        halt_ack;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  timer_count_compare_if bus ();

  timer_count_compare dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .halt_req (halt_req),
    .bus      (bus),
    .match    (match),
    .halt_ack (halt_ack)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // driver tasks
  task automatic set_wr(input logic cl, input logic ch, input logic ml,
                        input logic mh, input logic [31:0] d);
    bus.cnt_wr_lo = cl;
    bus.cnt_wr_hi = ch;
    bus.cmp_wr_lo = ml;
    bus.cmp_wr_hi = mh;
    bus.wdata     = d;
  endtask

  task automatic clr_wr();
    set_wr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic cl, input logic ch, input logic ml,
                    input logic mh, input logic [31:0] d);
    @(negedge sys_clk);
    set_wr(cl, ch, ml, mh, d);
    @(negedge sys_clk);
    clr_wr();
  endtask

  // reference model: the prescaler is described as a run of consecutive
  // eligible cycles, ticking on every (div_val+1)-th one
  logic [63:0]  m_cnt;
  logic [63:0]  m_cmp;
  logic         m_match;
  logic         m_hack;
  logic [3:0]   prev_dv;
  int           run_len;
  logic [129:0] exp_q[$];

  always @(posedge sys_clk) begin
    logic tk;
    logic elig;
    logic nm;
    if (sys_rst) begin
      m_cnt   = 64'h0;
      m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_match = 1'b0;
      m_hack  = 1'b0;
      prev_dv = 4'h0;
      run_len = 0;
    end else begin
      elig = timer_en && div_en && !halt_req && (div_val == prev_dv);
      if (!timer_en || halt_req) tk = 1'b0;
      else if (!div_en)          tk = 1'b1;
      else                       tk = elig && ((run_len % (int'(div_val) + 1)) == int'(div_val));
      nm = (m_cnt == m_cmp);
      if (bus.cnt_wr_lo || bus.cnt_wr_hi) begin
        if (bus.cnt_wr_lo) m_cnt[31:0]  = bus.wdata;
        if (bus.cnt_wr_hi) m_cnt[63:32] = bus.wdata;
      end else if (tk) begin
        m_cnt = m_cnt + 64'd1;
      end
      if (bus.cmp_wr_lo) m_cmp[31:0]  = bus.wdata;
      if (bus.cmp_wr_hi) m_cmp[63:32] = bus.wdata;
      m_match = nm;
      m_hack  = halt_req;
      run_len = elig ? run_len + 1 : 0;
      prev_dv = div_val;
    end
    exp_q.push_back({m_match, m_hack, m_cmp, m_cnt});
  end

  // scoreboard compare, every cycle
  always @(posedge sys_clk) begin
    logic [129:0] e;
    #1;
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk("sb_cnt", bus.cnt, e[63:0]);
      chk("sb_cmp", bus.cmp, e[127:64]);
      chk("sb_halt_ack", {63'h0, halt_ack}, {63'h0, e[128]});
      chk("sb_match", {63'h0, match}, {63'h0, e[129]});
    end
  end

  initial begin
    sys_rst = 1'b1; timer_en = 1'b0; div_en = 1'b0; div_val = 4'h0;
    halt_req = 1'b0;
    clr_wr();

    // reset values and no tick straight after release
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cnt", bus.cnt, 64'h0);
    chk("rst_cmp", bus.cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_match", {63'h0, match}, 64'h0);
    @(negedge sys_clk) sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    chk("no_tick_after_rst", bus.cnt, 64'h0);

    // undivided counting with cmp = 5
    wr(1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    wr(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    timer_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge sys_clk); #1;
      if (i == 5) begin
        chk("undiv_cnt5", bus.cnt, 64'd5);
        chk("undiv_match_pre", {63'h0, match}, 64'h0);
      end
      if (i == 6) chk("undiv_match_hi", {63'h0, match}, 64'h1);
      if (i == 7) chk("undiv_match_lo", {63'h0, match}, 64'h0);
    end
    chk("undiv_cnt10", bus.cnt, 64'd10);

    // prescaler divide-by-4, then switch to divide-by-2
    @(negedge sys_clk) begin timer_en = 1'b0; div_en = 1'b1; div_val = 4'd3; end
    @(negedge sys_clk) timer_en = 1'b1;
    repeat (16) @(posedge sys_clk);
    #1;
    chk("presc_16cyc", bus.cnt, 64'd14);
    @(negedge sys_clk) div_val = 4'd1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge sys_clk); #1;
      if (i == 1) chk("presc_chg_notick", bus.cnt, 64'd14);
      if (i == 2) chk("presc_div2_a", bus.cnt, 64'd14);
      if (i == 3) chk("presc_div2_b", bus.cnt, 64'd15);
      if (i == 5) chk("presc_div2_c", bus.cnt, 64'd16);
    end
    @(negedge sys_clk) begin timer_en = 1'b0; div_en = 1'b0; end

    // wrap, write priority, dual-half write, carry into the high half
    wr(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE);
    wr(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    timer_en = 1'b1;
    @(posedge sys_clk); #1; chk("wrap_max", bus.cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge sys_clk); #1; chk("wrap_zero", bus.cnt, 64'h0);
    @(negedge sys_clk) set_wr(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_ABCD);
    @(posedge sys_clk); #1; chk("prio_hi", bus.cnt, 64'h0000_ABCD_0000_0000);
    @(negedge sys_clk) set_wr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
    @(posedge sys_clk); #1; chk("prio_lo", bus.cnt, 64'h0000_ABCD_0000_1234);
    @(negedge sys_clk) clr_wr();
    @(posedge sys_clk); #1; chk("post_write_inc", bus.cnt, 64'h0000_ABCD_0000_1235);
    @(negedge sys_clk) set_wr(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0055);
    @(posedge sys_clk); #1; chk("both_halves", bus.cnt, 64'h0000_0055_0000_0055);
    @(negedge sys_clk) set_wr(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    @(posedge sys_clk); #1; chk("lo_no_carry", bus.cnt, 64'h0000_0055_FFFF_FFFF);
    @(negedge sys_clk) clr_wr();
    @(posedge sys_clk); #1; chk("carry_inc", bus.cnt, 64'h0000_0056_0000_0000);
    @(negedge sys_clk) timer_en = 1'b0;

    // halt with cnt = 100, compare written to 100 while halted
    wr(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    wr(1'b1, 1'b0, 1'b0, 1'b0, 32'd100);
    halt_req = 1'b1; timer_en = 1'b1;
    #1; chk("halt_ack_pre", {63'h0, halt_ack}, 64'h0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge sys_clk); #1;
      chk("halt_frozen", bus.cnt, 64'd100);
      if (i == 1) chk("halt_ack_rise", {63'h0, halt_ack}, 64'h1);
      if (i >= 4) chk("halt_match_held", {63'h0, match}, 64'h1);
      if (i == 2) begin @(negedge sys_clk); set_wr(1'b0, 1'b0, 1'b1, 1'b0, 32'd100); end
      if (i == 3) begin @(negedge sys_clk); clr_wr(); end
    end
    @(negedge sys_clk) halt_req = 1'b0;
    @(posedge sys_clk); #1;
    chk("halt_release_cnt", bus.cnt, 64'd101);
    chk("halt_release_match", {63'h0, match}, 64'h1);
    @(negedge sys_clk) timer_en = 1'b0;

    // simultaneous high-half writes making cnt == cmp
    wr(1'b1, 1'b0, 1'b1, 1'b0, 32'h77);
    wr(1'b0, 1'b1, 1'b0, 1'b0, 32'h11);
    set_wr(1'b0, 1'b1, 1'b0, 1'b1, 32'h22);
    @(posedge sys_clk); #1;
    chk("simul_cnt", bus.cnt, 64'h0000_0022_0000_0077);
    chk("simul_match_edge1", {63'h0, match}, 64'h0);
    @(negedge sys_clk) clr_wr();
    @(posedge sys_clk); #1;
    chk("simul_match_edge2", {63'h0, match}, 64'h1);

    // asynchronous reset mid-count
    @(negedge sys_clk) timer_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("async_rst_cnt", bus.cnt, 64'h0);
    chk("async_rst_cmp", bus.cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("async_rst_match", {63'h0, match}, 64'h0);
    @(negedge sys_clk) begin sys_rst = 1'b0; timer_en = 1'b0; end
    @(posedge sys_clk); #1;
    chk("async_rst_release", bus.cnt, 64'h0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge sys_clk);
      if (sys_rst) sys_rst = 1'b0;
      timer_en = ($urandom_range(0, 9) != 0);
      div_en   = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) div_val = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      clr_wr();
      r = $urandom_range(0, 19);
      case (r)
        0: set_wr(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 1) ? m_cmp[31:0] : $urandom);
        1: set_wr(1'b0, 1'b1, 1'b0, 1'b0, $urandom_range(0, 1) ? m_cmp[63:32] : $urandom);
        2: set_wr(1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 1) ? m_cnt[31:0] + 32'($urandom_range(0, 3)) : $urandom);
        3: set_wr(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 1) ? m_cnt[63:32] : $urandom);
        4: set_wr(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
        default: ;
      endcase
      if ($urandom_range(0, 399) == 0) #2 sys_rst = 1'b1;
    end
    @(negedge sys_clk) begin sys_rst = 1'b0; clr_wr(); end
    repeat (2) @(posedge sys_clk);
    #2;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
